// File: rtl/conv_1x1_multichannel.sv
// Streaming 1x1 convolution: serial per-channel MAC, bias, fixed-point
// rescale, saturation and optional ReLU, one output sample per pixel.
module conv_1x1_multichannel #(
  parameter int IMG_Width  = 3,
  parameter int IMG_Height = 3,
  parameter int Datawidth  = 16,
  parameter int CH_IN      = 4,
  parameter int FRAC       = 8,
  parameter int ReLU       = 0
) (
  input  logic                          CLK,
  input  logic                          CLR,
  input  logic signed [Datawidth-1:0]   In,
  input  logic                          Valid_IN,
  output logic                          Ready_IN,
  input  logic [CH_IN*Datawidth-1:0]    K,
  input  logic signed [Datawidth-1:0]   Bias,
  output logic signed [Datawidth-1:0]   Out,
  output logic                          Valid_OUT,
  input  logic                          Ready_OUT,
  output logic                          Last_OUT
);

  localparam int DW   = Datawidth;
  localparam int NPIX = IMG_Width * IMG_Height;
  localparam int CW   = (CH_IN > 1) ? $clog2(CH_IN) : 1;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int AW   = 2*DW + $clog2(CH_IN) + 1;
  localparam int SW   = AW + 1;

  localparam logic signed [SW-1:0] ONE  = {{(SW-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] SMAX = (ONE <<< (DW-1)) - ONE;
  localparam logic signed [SW-1:0] SMIN = -(ONE <<< (DW-1));

  logic [CW-1:0]          ch;
  logic [PW-1:0]          pix;
  logic signed [AW-1:0]   acc;

  logic                   accept;
  logic                   first;
  logic                   fin;
  logic                   last_pix;
  logic signed [DW-1:0]   k_sel;
  logic signed [2*DW-1:0] in_x;
  logic signed [2*DW-1:0] k_x;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   acc_nxt;
  logic signed [SW-1:0]   sum;
  logic signed [SW-1:0]   scaled;
  logic signed [DW-1:0]   res;

  assign Ready_IN = !Valid_OUT || Ready_OUT;
  assign accept   = Valid_IN && Ready_IN;
  assign first    = (ch == '0);
  assign fin      = accept && (ch == CW'(CH_IN-1));
  assign last_pix = (pix == PW'(NPIX-1));

  assign k_sel = K[ch*DW +: DW];
  assign in_x  = {{DW{In[DW-1]}}, In};
  assign k_x   = {{DW{k_sel[DW-1]}}, k_sel};
  assign prod  = in_x * k_x;

  // Channel 0 restarts the sum, which also covers CH_IN == 1.
  always_comb begin
    acc_nxt = (first ? '0 : acc) + AW'(prod);
    sum     = SW'(acc_nxt) + (SW'(Bias) <<< FRAC);
    scaled  = sum >>> FRAC;
    if (scaled > SMAX)
      res = {1'b0, {(DW-1){1'b1}}};
    else if (scaled < SMIN)
      res = {1'b1, {(DW-1){1'b0}}};
    else
      res = scaled[DW-1:0];
    if (ReLU != 0 && res[DW-1])
      res = '0;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      ch  <= '0;
      acc <= '0;
    end else if (accept) begin
      ch  <= fin ? '0 : ch + CW'(1);
      acc <= acc_nxt;
    end
  end

  // A finalize overrides a consume, so back-to-back results never bubble.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      pix       <= '0;
      Out       <= '0;
      Valid_OUT <= 1'b0;
      Last_OUT  <= 1'b0;
    end else if (fin) begin
      pix       <= last_pix ? '0 : pix + PW'(1);
      Out       <= res;
      Valid_OUT <= 1'b1;
      Last_OUT  <= last_pix;
    end else if (Ready_OUT) begin
      Valid_OUT <= 1'b0;
      Last_OUT  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_1x1_multichannel.sv
// Directed bench for conv_1x1_multichannel: MAC, bias, saturation, ReLU,
// backpressure, back-to-back results and asynchronous reset.
module tb_conv_1x1_multichannel;

  logic CLK = 1'b0;
  logic CLR = 1'b1;
  always #5 CLK = ~CLK;

  logic signed [15:0] In = '0;
  logic               Valid_IN = 1'b0;
  logic               Ready_OUT = 1'b1;
  logic [63:0]        K = '0;
  logic signed [15:0] Bias = '0;
  wire                Ready_IN, Valid_OUT, Last_OUT;
  wire [15:0]         Out;
  wire                rdy_r, v_r, l_r;
  wire [15:0]         out_r;

  logic signed [15:0] in1 = '0;
  logic               v1 = 1'b0;
  logic [15:0]        k1 = '0;
  logic               ro1 = 1'b1;
  wire                ri1, vo1, lo1;
  wire [15:0]         o1;

  int tests = 0;
  int fails = 0;

  conv_1x1_multichannel #(
    .IMG_Width(3), .IMG_Height(3), .Datawidth(16),
    .CH_IN(4), .FRAC(8), .ReLU(0)
  ) dut (
    .CLK(CLK), .CLR(CLR), .In(In), .Valid_IN(Valid_IN),
    .Ready_IN(Ready_IN), .K(K), .Bias(Bias), .Out(Out),
    .Valid_OUT(Valid_OUT), .Ready_OUT(Ready_OUT), .Last_OUT(Last_OUT)
  );

  conv_1x1_multichannel #(
    .IMG_Width(3), .IMG_Height(3), .Datawidth(16),
    .CH_IN(4), .FRAC(8), .ReLU(1)
  ) dut_r (
    .CLK(CLK), .CLR(CLR), .In(In), .Valid_IN(Valid_IN),
    .Ready_IN(rdy_r), .K(K), .Bias(Bias), .Out(out_r),
    .Valid_OUT(v_r), .Ready_OUT(Ready_OUT), .Last_OUT(l_r)
  );

  conv_1x1_multichannel #(
    .IMG_Width(3), .IMG_Height(3), .Datawidth(16),
    .CH_IN(1), .FRAC(8), .ReLU(0)
  ) dut1 (
    .CLK(CLK), .CLR(CLR), .In(in1), .Valid_IN(v1),
    .Ready_IN(ri1), .K(k1), .Bias(Bias), .Out(o1),
    .Valid_OUT(vo1), .Ready_OUT(ro1), .Last_OUT(lo1)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic set_k(input logic signed [15:0] w);
    K = {4{w}};
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic signed [15:0] v);
    int t;
    t = 0;
    In = v;
    Valid_IN = 1'b1;
    #1;
    while (!Ready_IN && t < 200) begin
      @(negedge CLK);
      #1;
      t++;
    end
    if (t >= 200) begin
      tests++;
      fails++;
      $display("FAIL push_timeout ready_in=%b want 1", Ready_IN);
    end
    @(negedge CLK);
    Valid_IN = 1'b0;
  endtask

  task automatic push4(input logic signed [15:0] v);
    for (int c = 0; c < 4; c++) push(v);
  endtask

  task automatic do_reset;
    @(negedge CLK);
    Valid_IN = 1'b0;
    v1 = 1'b0;
    Ready_OUT = 1'b1;
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    tests++;
    if (Out !== 16'h0000) begin
      fails++; $display("FAIL reset_out got %h want 0000", Out);
    end
    tests++;
    if (Valid_OUT !== 1'b0) begin
      fails++; $display("FAIL reset_valid got %b want 0", Valid_OUT);
    end
    tests++;
    if (Last_OUT !== 1'b0) begin
      fails++; $display("FAIL reset_last got %b want 0", Last_OUT);
    end
    tests++;
    if (Ready_IN !== 1'b1) begin
      fails++; $display("FAIL reset_ready got %b want 1", Ready_IN);
    end
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  task automatic test_basic_mac;
    do_reset();
    set_k(16'sd256);
    Bias = 0;
    push(16'sd256); push(16'sd512); push(16'sd768); push(16'sd1024);
    tests++;
    if (Valid_OUT !== 1'b1 || Out !== 16'h0A00) begin
      fails++;
      $display("FAIL basic_mac got v=%b %h want v=1 0a00", Valid_OUT, Out);
    end
    tests++;
    if (Last_OUT !== 1'b0) begin
      fails++; $display("FAIL basic_last got %b want 0", Last_OUT);
    end
    @(negedge CLK);
    tests++;
    if (Valid_OUT !== 1'b0) begin
      fails++; $display("FAIL basic_pulse got %b want 0", Valid_OUT);
    end
  endtask

  task automatic test_bias_frac;
    do_reset();
    set_k(16'sd128);
    Bias = 16'sd256;
    push4(16'sd256);
    tests++;
    if (Out !== 16'd768) begin
      fails++; $display("FAIL bias_half got %h want 0300", Out);
    end
    set_k(16'sd1);
    Bias = 0;
    push4(16'sd1);
    tests++;
    if (Out !== 16'h0000) begin
      fails++; $display("FAIL trunc_pos got %h want 0000", Out);
    end
    push4(-16'sd1);
    tests++;
    if (Out !== 16'hFFFF) begin
      fails++; $display("FAIL trunc_neg got %h want ffff", Out);
    end
  endtask

  task automatic test_channel_weights;
    do_reset();
    K = {16'hFF00, 16'h0000, 16'h0200, 16'h0100};
    Bias = 0;
    push4(16'sd256);
    tests++;
    if (Out !== 16'h0200) begin
      fails++; $display("FAIL chan_weights got %h want 0200", Out);
    end
    push(16'sd0); push(16'sd0); push(16'sd0); push(16'sd256);
    tests++;
    if (Out !== 16'hFF00) begin
      fails++; $display("FAIL chan3_weight got %h want ff00", Out);
    end
  endtask

  task automatic test_saturation;
    do_reset();
    set_k(16'sd32767);
    Bias = 0;
    push4(16'sd32767);
    tests++;
    if (Out !== 16'h7FFF) begin
      fails++; $display("FAIL sat_pos got %h want 7fff", Out);
    end
    push4(-16'sd32768);
    tests++;
    if (Out !== 16'h8000) begin
      fails++; $display("FAIL sat_neg got %h want 8000", Out);
    end
  endtask

  task automatic test_relu;
    do_reset();
    set_k(16'sd256);
    Bias = 0;
    push4(-16'sd256);
    tests++;
    if (Out !== 16'hFC00) begin
      fails++; $display("FAIL relu_off got %h want fc00", Out);
    end
    tests++;
    if (v_r !== 1'b1 || out_r !== 16'h0000) begin
      fails++; $display("FAIL relu_on got v=%b %h want v=1 0000", v_r, out_r);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    set_k(16'sd256);
    Bias = 0;
    fork
      begin
        for (int p = 0; p < 18; p++)
          for (int c = 0; c < 4; c++) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            push(16'(16 * (p + 1)));
          end
      end
      begin
        int idx = 0;
        int cyc = 0;
        int hold = 0;
        bit stalled = 0;
        logic [15:0] held = '0;
        while (idx < 18 && cyc < 3000) begin
          @(negedge CLK);
          cyc++;
          if (!stalled && Valid_OUT && idx == 4) begin
            hold = 5; stalled = 1; held = Out;
          end
          Ready_OUT = (hold == 0);
          #2;
          if (hold > 0) begin
            tests++;
            if (Ready_IN !== 1'b0 || Valid_OUT !== 1'b1 || Out !== held) begin
              fails++;
              $display("FAIL stall got rdy=%b v=%b %h want rdy=0 v=1 %h",
                       Ready_IN, Valid_OUT, Out, held);
            end
            hold--;
          end else if (Valid_OUT) begin
            tests++;
            if (Out !== 16'(64 * (idx + 1)) || Last_OUT !== (idx % 9 == 8)) begin
              fails++;
              $display("FAIL bp_out[%0d] got %h last=%b want %h last=%b", idx,
                       Out, Last_OUT, 16'(64 * (idx + 1)), idx % 9 == 8);
            end
            idx++;
          end
        end
        if (idx < 18) begin
          tests++; fails++;
          $display("FAIL bp_timeout got %0d outputs want 18", idx);
        end
        Ready_OUT = 1'b1;
      end
    join
  endtask

  task automatic test_back_to_back;
    do_reset();
    k1 = 16'd256;
    Bias = 0;
    ro1 = 1'b1;
    v1 = 1'b1;
    in1 = 16'sd100;
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      tests++;
      if (vo1 !== 1'b1 || ri1 !== 1'b1 || o1 !== 16'(100 * (i + 1))
          || lo1 !== (i == 8)) begin
        fails++;
        $display("FAIL b2b[%0d] got v=%b rdy=%b %h last=%b want v=1 rdy=1 %h last=%b",
                 i, vo1, ri1, o1, lo1, 16'(100 * (i + 1)), i == 8);
      end
      in1 = 16'(100 * (i + 2));
    end
    v1 = 1'b0;
    @(negedge CLK);
    tests++;
    if (vo1 !== 1'b0) begin
      fails++; $display("FAIL b2b_drain got %b want 0", vo1);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    set_k(16'sd256);
    Bias = 0;
    push4(16'sd100);
    Ready_OUT = 1'b0;
    #2;
    CLR = 1'b1;
    #1;
    tests++;
    if (Out !== 16'h0000 || Valid_OUT !== 1'b0 || Last_OUT !== 1'b0) begin
      fails++;
      $display("FAIL areset_pending got %h v=%b l=%b want 0000 v=0 l=0",
               Out, Valid_OUT, Last_OUT);
    end
    @(negedge CLK);
    CLR = 1'b0;
    Ready_OUT = 1'b1;
    push(16'sd5000);
    push(16'sd5000);
    #2;
    CLR = 1'b1;
    #1;
    tests++;
    if (Valid_OUT !== 1'b0 || Ready_IN !== 1'b1) begin
      fails++;
      $display("FAIL areset_partial got v=%b rdy=%b want v=0 rdy=1",
               Valid_OUT, Ready_IN);
    end
    @(negedge CLK);
    CLR = 1'b0;
    push4(16'sd256);
    tests++;
    if (Out !== 16'd1024 || Valid_OUT !== 1'b1 || Last_OUT !== 1'b0) begin
      fails++;
      $display("FAIL areset_first got %h v=%b l=%b want 0400 v=1 l=0",
               Out, Valid_OUT, Last_OUT);
    end
    for (int p = 0; p < 8; p++) begin
      push4(16'sd256);
      tests++;
      if (Last_OUT !== (p == 7)) begin
        fails++;
        $display("FAIL areset_last[%0d] got %b want %b", p, Last_OUT, p == 7);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_mac();
    test_bias_frac();
    test_channel_weights();
    test_saturation();
    test_relu();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_1x1_multichannel.md
# conv_1x1_multichannel

Streaming 1x1 convolution engine for multi-channel feature maps. For each pixel it takes CH_IN input-channel samples serially and multiplies each by its per-channel weight. It then accumulates the products at full precision, adds a bias, rescales from fixed point, saturates, optionally applies ReLU, and emits one output sample per pixel. It sits in the CNN datapath between a feature-map streamer and the next layer. Valid/ready handshakes on both sides give backpressure, and an end-of-frame marker flags the last pixel.

## Interface
Parameters:
- IMG_Width, 3, pixels per row
- IMG_Height, 3, rows per frame
- Datawidth, 16, sample/weight/bias/output width (signed two's complement)
- CH_IN, 4, input channels per pixel (>=1)
- FRAC, 8, fractional bits of the fixed-point format (0 <= FRAC < Datawidth)
- ReLU, 0, 1 = clamp negative results to 0

Ports:
- CLK  in  1  clock, all state on rising edge
- CLR  in  1  reset, asynchronous, active-high
- In  in  Datawidth  input sample for the current channel
- Valid_IN  in  1  In is valid
- Ready_IN  out  1  block accepts In this cycle
- K  in  CH_IN*Datawidth  weights; channel c at bits [c*Datawidth +: Datawidth]
- Bias  in  Datawidth  bias, same Q format as output
- Out  out  Datawidth  result sample
- Valid_OUT  out  1  Out is valid
- Ready_OUT  in  1  downstream accepts Out
- Last_OUT  out  1  Out belongs to last pixel of frame

## Operation
- Accept = Valid_IN && Ready_IN.
- Only accept advances state. Gaps in Valid_IN are allowed anywhere, including mid-pixel.
- Channel counter ch runs 0..CH_IN-1 and increments on each accept. It wraps to 0 after the accept at CH_IN-1.
- Product: signed In * signed K[ch], 2*Datawidth bits.
- Accumulator width: 2*Datawidth + clog2(CH_IN) + 1 bits, signed. It does not overflow.
- On accept with ch==0, acc = product. Otherwise, acc = acc + product.
- Finalize on accept with ch==CH_IN-1:
  - sum = acc + product + (sign-extended Bias <<< FRAC).
  - scaled = sum >>> FRAC. This is an arithmetic shift that truncates toward minus infinity.
  - Saturate scaled to [-2^(Datawidth-1), 2^(Datawidth-1)-1].
  - If ReLU==1 and the result is negative, it becomes 0.
- The finalized result is registered into Out. Valid_OUT is set. Last_OUT = (pix == IMG_Width*IMG_Height-1).
- Pixel counter pix runs 0..IMG_Width*IMG_Height-1 and increments at each finalize. It wraps to 0 after the last pixel, so the next frame starts without a gap.
- K and Bias are sampled combinationally at accept time. The source holds them stable for the whole frame.
- Output register:
  - Valid_OUT clears when Ready_OUT && !new finalize.
  - Out and Last_OUT hold their value while Valid_OUT && !Ready_OUT.
- Ready_IN = !Valid_OUT || Ready_OUT (combinational). All channel input stalls while a result is pending and unconsumed.
- Simultaneous consume + finalize (Valid_OUT && Ready_OUT && finalizing accept): the new result replaces the old one and Valid_OUT stays 1. No bubble and no loss.
- Reset (CLR=1, asynchronous, any time including mid-pixel):
  - Out=0, Valid_OUT=0, Last_OUT=0.
  - ch=0, pix=0, acc=0.
  - The partial pixel is discarded. The first accept after release is channel 0 of pixel 0.

## Timing
- Latency: Out/Valid_OUT are valid on the rising edge after the accept of channel CH_IN-1. That is one cycle of latency from the last channel.
- Throughput: one pixel per CH_IN accepted cycles. Sustained when Ready_OUT=1.
- Ready_IN depends combinationally on Ready_OUT and registered Valid_OUT. No other combinational in-to-out path exists.
- Handshake rules:
  - Out, Valid_OUT and Last_OUT are stable while Valid_OUT && !Ready_OUT.
  - Valid_OUT never drops without a transfer.
- Last_OUT is high only while Valid_OUT is high, for exactly one transferred sample per frame.

## Test plan
Defaults for all scenarios: Datawidth=16, FRAC=8, CH_IN=4, 3x3 frame.
- Basic MAC: K all 256 (1.0), Bias 0, In=256,512,768,1024 back-to-back, Ready_OUT=1 -> Out=2560 (0x0A00) one cycle after the 4th accept, Valid_OUT high for 1 cycle.
- Bias/fraction: K all 128 (0.5), In 4x256, Bias=256 -> Out=768. Then In=1 with K=1 for all channels, Bias 0 -> Out=0 (truncation).
- Saturation: In=32767, K=32767 all channels -> Out=0x7FFF. In=-32768, K=32767 -> Out=0x8000.
- ReLU: In 4x -256, K 256, Bias 0. ReLU=0 -> Out=0xFC00. ReLU=1 -> Out=0x0000.
- Backpressure/gaps: random Valid_IN gaps plus Ready_OUT held low 5 cycles with a result pending.
  - Ready_IN stays low and Out stays stable throughout.
  - All 9 pixels are delivered in order with no duplicates or drops.
  - A consume and a finalize in the same cycle keeps Valid_OUT high.
  - Last_OUT is set only on the 9th output. Frame 2 restarts at pix 0.
- Async reset: assert CLR between clock edges after 2 channels accepted, with Valid_OUT high.
  - Valid_OUT/Out/Last_OUT go to 0 immediately.
  - After release, 4 new channels (In=256, K=256) produce Out=1024, marked as pixel 0.
